// File: rtl/mem_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_pkg
// Description : Shared types and constants for the EX/MEM and MEM/WB pipeline
//               registers and the data-memory wait controller.
//               - wait_state_e : controller states (ACCESS / WAIT)
//               - ex_ctrl_t    : EX-stage control bundle carried into EX/MEM
//               - CTRL_BUBBLE  : control bundle of a pipeline bubble
//               - DW_DEFAULT   : default datapath width
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pipe_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [0:0] {
    ST_ACCESS = 1'b0,
    ST_WAIT   = 1'b1
  } wait_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_ctrl
// Description : Data-memory access sequencer. Stalls the pipeline while an
//               access waits for mem_ready and aborts it once the wait budget
//               is used up.
// Ports       : clk, reset (async, active-low)
//               access_req  - EX/MEM holds a load or store
//               mem_ready   - memory completes the access this cycle
//               stall       - hold the pipeline this cycle
//               abort       - access is force-completed this cycle
//               mem_timeout - one-cycle pulse in the abort cycle
//               mem_err     - sticky abort flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_ctrl
  import mem_wb_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic access_req,
  input  logic mem_ready,
  output logic stall,
  output logic abort,
  output logic mem_timeout,
  output logic mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  wait_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;

  // cnt_q holds the number of cycles the current access has already stalled.
  // The first (ACCESS) cycle is stalled cycle 0, so leaving ACCESS loads 1;
  // the abort then lands exactly MAX_WAIT-1 stalled cycles after the start.
  always_comb begin
    abort     = (state_q == ST_WAIT) && (cnt_q == CNT_LAST) && !mem_ready;
    stall     = access_req && !mem_ready && !abort;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q | abort;

    case (state_q)
      ST_ACCESS: begin
        if (stall) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready || abort) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ACCESS;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_timeout = abort;
  assign mem_err     = mem_err_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : EX/MEM and MEM/WB pipeline registers of the five-stage core.
//               Drives the forwarding producer signals (EXtoMEM_*, MEMtoWB_*),
//               presents the data-memory request from EX/MEM and stalls the
//               upstream pipeline while the access waits.
// Ports       : clk, reset (async, active-low)
//               ex_*        - EX-stage controls, destination, result, store data
//               flush       - capture a bubble instead of the EX instruction
//               EXtoMEM_*   - EX/MEM contents for forwarding
//               MEMtoWB_*   - MEM/WB contents, also the register-file write port
//               mem_*       - data-memory request / response
//               stall_out   - freeze PC, IF/ID, ID/EX this cycle
//               mem_timeout - pulse on aborted access; mem_err - sticky abort
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_RegWrite,
  input  logic          ex_MemRead,
  input  logic          ex_MemWrite,
  input  logic          ex_MemtoReg,
  input  logic [4:0]    ex_RegRd,
  input  logic [DW-1:0] ex_ALUOut,
  input  logic [DW-1:0] ex_StoreData,
  input  logic          flush,
  output logic          EXtoMEM_RegWrite,
  output logic [4:0]    EXtoMEM_RegRd,
  output logic [DW-1:0] EXtoMEM_ALUOut,
  output logic          MEMtoWB_RegWrite,
  output logic [4:0]    MEMtoWB_RegRd,
  output logic [DW-1:0] MEMtoWB_WriteData,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_out,
  output logic          mem_timeout,
  output logic          mem_err
);

  ex_ctrl_t      exmem_ctrl_q, exmem_ctrl_d;
  logic [4:0]    exmem_rd_q, exmem_rd_d;
  logic [DW-1:0] exmem_alu_q, exmem_alu_d;
  logic [DW-1:0] exmem_store_q, exmem_store_d;

  logic          memwb_we_q, memwb_we_d;
  logic [4:0]    memwb_rd_q, memwb_rd_d;
  logic [DW-1:0] memwb_data_q, memwb_data_d;

  logic          stall;
  logic          abort;

  mem_wait_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctrl (
    .clk         (clk),
    .reset       (reset),
    .access_req  (exmem_ctrl_q.mem_read | exmem_ctrl_q.mem_write),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .abort       (abort),
    .mem_timeout (mem_timeout),
    .mem_err     (mem_err)
  );

  // Both stages hold while stalled; flush only matters when EX/MEM advances,
  // so a stalled access can never be replaced by a bubble.
  always_comb begin
    exmem_ctrl_d  = exmem_ctrl_q;
    exmem_rd_d    = exmem_rd_q;
    exmem_alu_d   = exmem_alu_q;
    exmem_store_d = exmem_store_q;
    memwb_we_d    = memwb_we_q;
    memwb_rd_d    = memwb_rd_q;
    memwb_data_d  = memwb_data_q;

    if (!stall) begin
      if (flush) begin
        exmem_ctrl_d  = CTRL_BUBBLE;
        exmem_rd_d    = '0;
        exmem_alu_d   = '0;
        exmem_store_d = '0;
      end else begin
        exmem_ctrl_d  = '{reg_write:  ex_RegWrite,
                          mem_read:   ex_MemRead,
                          mem_write:  ex_MemWrite,
                          mem_to_reg: ex_MemtoReg};
        exmem_rd_d    = ex_RegRd;
        exmem_alu_d   = ex_ALUOut;
        exmem_store_d = ex_StoreData;
      end

      memwb_we_d = exmem_ctrl_q.reg_write;
      memwb_rd_d = exmem_rd_q;
      // An aborted load writes 0 rather than whatever is on the data bus.
      if (exmem_ctrl_q.mem_to_reg) begin
        memwb_data_d = abort ? '0 : mem_rdata;
      end else begin
        memwb_data_d = exmem_alu_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exmem_ctrl_q  <= CTRL_BUBBLE;
      exmem_rd_q    <= '0;
      exmem_alu_q   <= '0;
      exmem_store_q <= '0;
      memwb_we_q    <= 1'b0;
      memwb_rd_q    <= '0;
      memwb_data_q  <= '0;
    end else begin
      exmem_ctrl_q  <= exmem_ctrl_d;
      exmem_rd_q    <= exmem_rd_d;
      exmem_alu_q   <= exmem_alu_d;
      exmem_store_q <= exmem_store_d;
      memwb_we_q    <= memwb_we_d;
      memwb_rd_q    <= memwb_rd_d;
      memwb_data_q  <= memwb_data_d;
    end
  end

  assign EXtoMEM_RegWrite  = exmem_ctrl_q.reg_write;
  assign EXtoMEM_RegRd     = exmem_rd_q;
  assign EXtoMEM_ALUOut    = exmem_alu_q;

  assign MEMtoWB_RegWrite  = memwb_we_q;
  assign MEMtoWB_RegRd     = memwb_rd_q;
  assign MEMtoWB_WriteData = memwb_data_q;

  assign mem_rd    = exmem_ctrl_q.mem_read;
  assign mem_wr    = exmem_ctrl_q.mem_write;
  assign mem_addr  = exmem_alu_q;
  assign mem_wdata = exmem_store_q;
  assign stall_out = stall;

endmodule
`default_nettype wire
